// File: rtl/approx_adder_error_monitor.sv
// Error-metric accumulator for an approximate adder: counts mismatches, sums and tracks the peak |exact - approx| over a window.
// Optional Hamming-distance accumulation (err_bits output) is enabled with `define APPROX_MON_HAMMING_EN.
module approx_adder_error_monitor #(
    parameter int WIDTH       = 16,
    parameter int NUM_SAMPLES = 10000,
    parameter int ACC_W       = 40,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    input  logic [WIDTH:0]   approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] err_total,
    output logic [WIDTH:0]   err_max
`ifdef APPROX_MON_HAMMING_EN
    ,
    output logic [CNT_W-1:0] err_bits
`endif
);

    localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             w_accept;
    logic             w_start;
    logic             w_last;
    logic [WIDTH:0]   w_exact;

    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_exact;
    logic [WIDTH:0]   r_s1_approx;

    logic             w_s1_ge;
    logic [WIDTH:0]   w_dist;
    logic             w_mismatch;

    logic             r_s2_valid;
    logic [WIDTH:0]   r_s2_dist;
    logic             r_s2_mismatch;

    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_err_count;
    logic [ACC_W-1:0] r_err_total;
    logic [WIDTH:0]   r_err_max;

    logic [SUM_W-1:0] w_total_sum;
    logic [ACC_W-1:0] w_total_sat;

    assign w_accept = in_valid && (r_state == S_RUN);
    assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_sample_count == CNT_W'(NUM_SAMPLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_last) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Once stage 1 is empty, stage 2 retires on this edge, so results are final in DONE.
                if (!r_s1_valid) w_state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_exact = ({1'b0, op_a} + {1'b0, op_b}) + {{WIDTH{1'b0}}, carry_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_exact  <= w_exact;
                r_s1_approx <= approx_sum;
            end
        end
    end

    // Compare-and-subtract keeps the distance unsigned and free of wrap-around.
    assign w_s1_ge    = (r_s1_exact >= r_s1_approx);
    assign w_dist     = w_s1_ge ? (r_s1_exact - r_s1_approx) : (r_s1_approx - r_s1_exact);
    assign w_mismatch = (r_s1_exact != r_s1_approx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_dist     <= '0;
            r_s2_mismatch <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_dist     <= w_dist;
                r_s2_mismatch <= w_mismatch;
            end
        end
    end

    assign w_total_sum = SUM_W'(r_err_total) + SUM_W'(r_s2_dist);
    assign w_total_sat = (w_total_sum > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}}
                                                               : w_total_sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_err_total    <= '0;
            r_err_max      <= '0;
        end else if (w_start) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_err_total    <= '0;
            r_err_max      <= '0;
        end else begin
            if (w_accept) begin
                r_sample_count <= r_sample_count + CNT_W'(1);
            end
            if (r_s2_valid) begin
                r_err_count <= r_err_count + CNT_W'(r_s2_mismatch);
                r_err_total <= w_total_sat;
                if (r_s2_dist > r_err_max) begin
                    r_err_max <= r_s2_dist;
                end
            end
        end
    end

    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign err_total    = r_err_total;
    assign err_max      = r_err_max;

`ifdef APPROX_MON_HAMMING_EN
    localparam int POP_W = $clog2(WIDTH + 2);

    logic [WIDTH:0]   w_diff_bits;
    logic [POP_W-1:0] w_pop;
    logic [POP_W-1:0] r_s2_pop;
    logic [CNT_W:0]   w_bits_sum;
    logic [CNT_W-1:0] r_err_bits;

    assign w_diff_bits = r_s1_exact ^ r_s1_approx;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            w_pop = w_pop + POP_W'(w_diff_bits[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_pop <= '0;
        end else if (r_s1_valid) begin
            r_s2_pop <= w_pop;
        end
    end

    assign w_bits_sum = {1'b0, r_err_bits} + (CNT_W + 1)'(r_s2_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_bits <= '0;
        end else if (w_start) begin
            r_err_bits <= '0;
        end else if (r_s2_valid) begin
            r_err_bits <= w_bits_sum[CNT_W] ? {CNT_W{1'b1}} : w_bits_sum[CNT_W-1:0];
        end
    end

    assign err_bits = r_err_bits;
`endif

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Scoreboard bench: three monitor instances (short window, 10000-sample stream, 17-bit saturating total).
module tb_approx_adder_error_monitor;

    localparam int NS0 = 4;
    localparam int NS1 = 10000;
    localparam int NS2 = 3;
    localparam int AW0 = 40;
    localparam int AW1 = 40;
    localparam int AW2 = 17;

    typedef struct {
        longint sc;
        longint ec;
        longint et;
        longint em;
        longint eb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v;
    logic        in_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        carry_in;
    logic [16:0] approx_sum;

    logic        rdy0, busy0, done0, rdy1, busy1, done1, rdy2, busy2, done2;
    logic [31:0] sc0, ec0, sc1, ec1, sc2, ec2;
    logic [39:0] tot0, tot1;
    logic [16:0] tot2;
    logic [16:0] mx0, mx1, mx2;
`ifdef APPROX_MON_HAMMING_EN
    logic [31:0] eb0, eb1, eb2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    longint m_sc, m_ec, m_et, m_em, m_eb, m_lim;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    approx_adder_error_monitor #(.WIDTH(16), .NUM_SAMPLES(NS0), .ACC_W(AW0), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy0),
        .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .approx_sum(approx_sum),
        .busy(busy0), .done(done0), .sample_count(sc0), .err_count(ec0),
        .err_total(tot0), .err_max(mx0)
`ifdef APPROX_MON_HAMMING_EN
        , .err_bits(eb0)
`endif
    );

    approx_adder_error_monitor #(.WIDTH(16), .NUM_SAMPLES(NS1), .ACC_W(AW1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy1),
        .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .approx_sum(approx_sum),
        .busy(busy1), .done(done1), .sample_count(sc1), .err_count(ec1),
        .err_total(tot1), .err_max(mx1)
`ifdef APPROX_MON_HAMMING_EN
        , .err_bits(eb1)
`endif
    );

    approx_adder_error_monitor #(.WIDTH(16), .NUM_SAMPLES(NS2), .ACC_W(AW2), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy2),
        .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .approx_sum(approx_sum),
        .busy(busy2), .done(done2), .sample_count(sc2), .err_count(ec2),
        .err_total(tot2), .err_max(mx2)
`ifdef APPROX_MON_HAMMING_EN
        , .err_bits(eb2)
`endif
    );

    task automatic check(input string nm, input longint act, input longint expv);
        n_tests = n_tests + 1;
        if (act != expv) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic peek(input int k, output exp_t o, output logic r, output logic b, output logic d);
        o.eb = 0;
        case (k)
            0: begin
                o.sc = sc0; o.ec = ec0; o.et = tot0; o.em = mx0; r = rdy0; b = busy0; d = done0;
`ifdef APPROX_MON_HAMMING_EN
                o.eb = eb0;
`endif
            end
            1: begin
                o.sc = sc1; o.ec = ec1; o.et = tot1; o.em = mx1; r = rdy1; b = busy1; d = done1;
`ifdef APPROX_MON_HAMMING_EN
                o.eb = eb1;
`endif
            end
            default: begin
                o.sc = sc2; o.ec = ec2; o.et = tot2; o.em = mx2; r = rdy2; b = busy2; d = done2;
`ifdef APPROX_MON_HAMMING_EN
                o.eb = eb2;
`endif
            end
        endcase
    endtask

    task automatic check_metrics(input string nm, input exp_t act, input exp_t e);
        check({nm, ".sample_count"}, act.sc, e.sc);
        check({nm, ".err_count"}, act.ec, e.ec);
        check({nm, ".err_total"}, act.et, e.et);
        check({nm, ".err_max"}, act.em, e.em);
`ifdef APPROX_MON_HAMMING_EN
        check({nm, ".err_bits"}, act.eb, e.eb);
`endif
    endtask

    // Reference model: plain arithmetic on the operands, independent of pipeline timing.
    task automatic model_clear(input int k);
        m_sc = 0; m_ec = 0; m_et = 0; m_em = 0; m_eb = 0;
        m_lim = (k == 2) ? ((64'sd1 <<< AW2) - 1) : ((64'sd1 <<< AW0) - 1);
    endtask

    task automatic model_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                             input logic [16:0] ap);
        longint ex, apl, d;
        logic [16:0] exv;
        ex  = longint'(a) + longint'(b) + longint'(c);
        apl = longint'(ap);
        d   = (ex > apl) ? ex - apl : apl - ex;
        exv = 17'(ex);
        m_sc = m_sc + 1;
        if (d != 0) m_ec = m_ec + 1;
        m_et = (m_et + d > m_lim) ? m_lim : m_et + d;
        if (d > m_em) m_em = d;
        m_eb = m_eb + longint'($countones(exv ^ ap));
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.sc = m_sc; e.ec = m_ec; e.et = m_et; e.em = m_em; e.eb = m_eb;
        return e;
    endfunction

    task automatic begin_window(input int k);
        exp_t o;
        logic r, b, d;
        @(posedge clk); #1;
        start_v[k] = 1'b1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        in_valid   = 1'b0;
        peek(k, o, r, b, d);
        model_clear(k);
        check_metrics($sformatf("start_clear%0d", k), o, model_snapshot());
        check($sformatf("start_ready%0d", k), longint'(r), 1);
    endtask

    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [16:0] ap);
        exp_t o;
        logic r, bz, d;
        int g;
        op_a = a; op_b = b; carry_in = c; approx_sum = ap;
        in_valid = 1'b1;
        @(negedge clk);
        peek(k, o, r, bz, d);
        g = 0;
        while (!r && g < 50) begin
            @(negedge clk);
            peek(k, o, r, bz, d);
            g = g + 1;
        end
        if (!r) check($sformatf("ready_timeout%0d", k), 0, 1);
        else model_add(a, b, c, ap);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic rand_sample(input int k);
        logic [15:0] a, b;
        logic c;
        logic [16:0] ex, ap;
        a  = 16'($urandom);
        b  = 16'($urandom);
        c  = 1'($urandom);
        ex = {1'b0, a} + {1'b0, b} + {16'b0, c};
        case ($urandom_range(0, 3))
            0: ap = ex;
            1: ap = ex ^ (17'd1 << $urandom_range(0, 16));
            2: ap = 17'($urandom);
            default: ap = ex + 17'($urandom_range(0, 7));
        endcase
        send(k, a, b, c, ap);
    endtask

    task automatic push_expected(input int k);
        case (k)
            0: q0.push_back(model_snapshot());
            1: q1.push_back(model_snapshot());
            default: q2.push_back(model_snapshot());
        endcase
    endtask

    task automatic wait_done(input int k);
        exp_t o;
        logic r, b, d;
        int g;
        g = 0;
        @(negedge clk);
        peek(k, o, r, b, d);
        while (!d && g < 30) begin
            @(negedge clk);
            peek(k, o, r, b, d);
            g = g + 1;
        end
        if (!d) check($sformatf("done_timeout%0d", k), 0, 1);
    endtask

    // Monitor: pops one expected window per rising done on each instance.
    initial begin
        logic [2:0] done_prev;
        exp_t o, e;
        logic r, b, d;
        int qs;
        done_prev = 3'b000;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                peek(k, o, r, b, d);
                if (d && !done_prev[k]) begin
                    qs = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
                    if (qs == 0) begin
                        check($sformatf("unexpected_done%0d", k), 1, 0);
                    end else begin
                        case (k)
                            0: e = q0.pop_front();
                            1: e = q1.pop_front();
                            default: e = q2.pop_front();
                        endcase
                        check_metrics($sformatf("window%0d", k), o, e);
                        $display("[TB] window inst%0d samples=%0d errs=%0d total=%0d max=%0d bits=%0d",
                                 k, o.sc, o.ec, o.et, o.em, o.eb);
                    end
                end
                done_prev[k] = d;
            end
        end
    end

    initial begin
        exp_t o;
        logic r, b, d;
        int t0;
        start_v = 3'b000;
        in_valid = 1'b1;
        op_a = 16'h1234; op_b = 16'h4321; carry_in = 1'b1; approx_sum = 17'h0;

        repeat (3) @(negedge clk);
        peek(0, o, r, b, d);
        model_clear(0);
        check_metrics("reset", o, model_snapshot());
        check("reset.in_ready", longint'(r), 0);
        check("reset.busy", longint'(b), 0);
        check("reset.done", longint'(d), 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        peek(0, o, r, b, d);
        check("idle.sample_count", o.sc, 0);
        check("idle.in_ready", longint'(r), 0);
        in_valid = 1'b0;

        // Exact-match window.
        begin_window(0);
        repeat (4) send(0, 16'hFFFF, 16'h0001, 1'b1, 17'h10001);
        push_expected(0);
        wait_done(0);

        // Error magnitude in both directions, plus a start pulse mid-run that must be ignored.
        begin_window(0);
        send(0, 16'hFFFF, 16'h0001, 1'b1, 17'h00001);
        send(0, 16'h0005, 16'h0003, 1'b0, 17'd10);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        peek(0, o, r, b, d);
        check("run_start_ignored", o.sc, m_sc);
        send(0, 16'h0100, 16'h0200, 1'b0, 17'h00300);
        send(0, 16'h8000, 16'h8000, 1'b1, 17'h10001);
        push_expected(0);
        wait_done(0);

        // Random windows with random gaps.
        for (int w = 0; w < 5; w++) begin
            begin_window(0);
            for (int s = 0; s < NS0; s++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                rand_sample(0);
            end
            push_expected(0);
            wait_done(0);
        end

        // Saturating total with a 17-bit accumulator.
        begin_window(2);
        repeat (3) send(2, 16'hFFFF, 16'h0001, 1'b1, 17'h00001);
        push_expected(2);
        wait_done(2);

        // Full-rate stream of 10000 samples.
        begin_window(1);
        t0 = cyc;
        for (int s = 0; s < NS1; s++) rand_sample(1);
        check("stream_no_bubbles", longint'(cyc - t0), longint'(NS1));
        push_expected(1);
        @(negedge clk);
        peek(1, o, r, b, d);
        check("drain.in_ready", longint'(r), 0);
        check("drain.busy", longint'(b), 1);
        check("drain.done_c0", longint'(d), 0);
        @(negedge clk);
        peek(1, o, r, b, d);
        check("drain.done_c1", longint'(d), 0);
        @(negedge clk);
        peek(1, o, r, b, d);
        check("drain.done_c2", longint'(d), 1);

        // Reset in the middle of RUN.
        begin_window(0);
        rand_sample(0);
        rand_sample(0);
        rst_n = 1'b0;
        #1;
        peek(0, o, r, b, d);
        model_clear(0);
        check_metrics("midrun_reset", o, model_snapshot());
        check("midrun_reset.busy", longint'(b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        peek(0, o, r, b, d);
        check("after_reset.in_ready", longint'(r), 0);
        check("after_reset.sample_count", o.sc, 0);

        // Reset during DRAIN: results discarded, done never rises.
        begin_window(0);
        repeat (NS0) rand_sample(0);
        rst_n = 1'b0;
        #1;
        peek(0, o, r, b, d);
        check("middrain_reset.busy", longint'(b), 0);
        check("middrain_reset.sample_count", o.sc, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        peek(0, o, r, b, d);
        check("middrain_reset.done", longint'(d), 0);
        check("middrain_reset.err_total", o.et, 0);

        // Fresh window after reset.
        begin_window(0);
        repeat (NS0) rand_sample(0);
        push_expected(0);
        wait_done(0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", longint'(q0.size() + q1.size() + q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
